// File: rtl/clock_pkg.sv
// Shared encodings and limits for the alarm clock controller.
package clock_pkg;

  typedef enum logic [2:0] {
    ModeRun   = 3'd0,
    ModeSetTh = 3'd1,
    ModeSetTm = 3'd2,
    ModeSetAh = 3'd3,
    ModeSetAm = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    AlIdle    = 2'd0,
    AlRinging = 2'd1,
    AlSnooze  = 2'd2
  } alarm_e;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // Mode_btn walks the set modes in a fixed ring back to RUN.
  function automatic mode_e next_mode(mode_e m);
    case (m)
      ModeRun:   return ModeSetTh;
      ModeSetTh: return ModeSetTm;
      ModeSetTm: return ModeSetAh;
      ModeSetAh: return ModeSetAm;
      default:   return ModeRun;
    endcase
  endfunction

endpackage

// File: rtl/rise_edge.sv
// One-flop rising-edge detector for a synchronous, debounced button level.
module rise_edge (
  input  logic Clk,
  input  logic Clr,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // Level history; pulse is high while the level is new.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) level_q <= 1'b0;
    else      level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Alarm clock controller: timekeeping pulses, set modes and alarm ring/snooze.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Sec_tick,
  input  logic       Mode_btn,
  input  logic       Inc_btn,
  input  logic       Snooze_btn,
  input  logic       Alarm_en,
  input  logic [4:0] Time_H,
  input  logic [5:0] Time_M,
  input  logic [5:0] Time_S,
  input  logic [4:0] Alarm_H,
  input  logic [5:0] Alarm_M,
  output logic       S_up,
  output logic       M_up,
  output logic       H_up,
  output logic       AH_up,
  output logic       AM_up,
  output logic       S_clr_n,
  output logic [2:0] Mode,
  output logic       Blink,
  output logic       Ring
);

  localparam int unsigned CntMax = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic mode_edge, inc_edge, snooze_edge;

  rise_edge u_mode_edge (.Clk(Clk), .Clr(Clr), .level(Mode_btn),   .pulse(mode_edge));
  rise_edge u_inc_edge  (.Clk(Clk), .Clr(Clr), .level(Inc_btn),    .pulse(inc_edge));
  rise_edge u_snz_edge  (.Clk(Clk), .Clr(Clr), .level(Snooze_btn), .pulse(snooze_edge));

  mode_e             mode_q, mode_d;
  alarm_e            al_q, al_d;
  logic [CntW-1:0]   ring_cnt_q, ring_cnt_d, snz_cnt_q, snz_cnt_d;
  logic              match_q, match_d;
  logic              s_up_q, s_up_d, m_up_q, m_up_d, h_up_q, h_up_d;
  logic              ah_up_q, ah_up_d, am_up_q, am_up_d;
  logic              s_clr_n_q, s_clr_n_d, blink_q, blink_d, ring_q, ring_d;

  // Mode sequencing, counter pulses and blink.
  always_comb begin
    mode_d    = mode_q;
    s_up_d    = 1'b0;
    m_up_d    = 1'b0;
    h_up_d    = 1'b0;
    ah_up_d   = 1'b0;
    am_up_d   = 1'b0;
    s_clr_n_d = 1'b1;
    if (mode_edge) begin
      // A simultaneous Inc edge is dropped here on purpose.
      mode_d = next_mode(mode_q);
      if (mode_q == ModeSetTm) s_clr_n_d = 1'b0;
    end else if (inc_edge) begin
      unique case (mode_q)
        ModeSetTh: h_up_d  = 1'b1;
        ModeSetTm: m_up_d  = 1'b1;
        ModeSetAh: ah_up_d = 1'b1;
        ModeSetAm: am_up_d = 1'b1;
        default:   ;
      endcase
    end
    if (mode_q == ModeRun && Sec_tick) begin
      s_up_d = 1'b1;
      m_up_d = (Time_S == SEC_MAX);
      h_up_d = (Time_S == SEC_MAX) && (Time_M == MIN_MAX);
    end
    blink_d = (mode_d == ModeRun) ? 1'b0 : (blink_q ^ Sec_tick);
  end

  // Alarm trigger edge, ring/snooze sequencing and their second counters.
  always_comb begin
    al_d       = al_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    match_d    = (mode_q == ModeRun) && Alarm_en && (Time_H == Alarm_H) &&
                 (Time_M == Alarm_M) && (Time_S == '0);
    if (!Alarm_en || mode_edge) begin
      al_d       = AlIdle;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      unique case (al_q)
        AlIdle: begin
          if (match_d && !match_q) begin
            al_d       = AlRinging;
            ring_cnt_d = CntW'(RING_SEC);
          end
        end
        AlRinging: begin
          if (snooze_edge) begin
            al_d      = AlSnooze;
            snz_cnt_d = CntW'(SNOOZE_SEC);
          end else if (ring_cnt_q == '0 || (Sec_tick && ring_cnt_q == CntW'(1))) begin
            al_d       = AlIdle;
            ring_cnt_d = '0;
          end else if (Sec_tick) begin
            ring_cnt_d = ring_cnt_q - CntW'(1);
          end
        end
        AlSnooze: begin
          if (snz_cnt_q == '0 || (Sec_tick && snz_cnt_q == CntW'(1))) begin
            al_d       = AlRinging;
            snz_cnt_d  = '0;
            ring_cnt_d = CntW'(RING_SEC);
          end else if (Sec_tick) begin
            snz_cnt_d = snz_cnt_q - CntW'(1);
          end
        end
        default: al_d = AlIdle;
      endcase
    end
    ring_d = (al_d == AlRinging);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mode_q     <= ModeRun;
      al_q       <= AlIdle;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      match_q    <= 1'b0;
      s_up_q     <= 1'b0;
      m_up_q     <= 1'b0;
      h_up_q     <= 1'b0;
      ah_up_q    <= 1'b0;
      am_up_q    <= 1'b0;
      s_clr_n_q  <= 1'b1;
      blink_q    <= 1'b0;
      ring_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      al_q       <= al_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      match_q    <= match_d;
      s_up_q     <= s_up_d;
      m_up_q     <= m_up_d;
      h_up_q     <= h_up_d;
      ah_up_q    <= ah_up_d;
      am_up_q    <= am_up_d;
      s_clr_n_q  <= s_clr_n_d;
      blink_q    <= blink_d;
      ring_q     <= ring_d;
    end
  end

  assign S_up    = s_up_q;
  assign M_up    = m_up_q;
  assign H_up    = h_up_q;
  assign AH_up   = ah_up_q;
  assign AM_up   = am_up_q;
  assign S_clr_n = s_clr_n_q;
  assign Mode    = mode_q;
  assign Blink   = blink_q;
  assign Ring    = ring_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus random traffic against a
// second-level behavioural model of the controller.
module tb_clock_mode_ctrl;

  localparam int RING   = 60;
  localparam int SNOOZE = 300;
  localparam logic [10:0] RST_VEC = 11'b00000_1_000_0_0;

  logic       Clk = 1'b0;
  logic       Clr;
  logic       tick, mbtn, ibtn, sbtn, en;
  logic [4:0] th, ah;
  logic [5:0] tm, ts, am;
  logic       S_up, M_up, H_up, AH_up, AM_up, S_clr_n, Blink, Ring;
  logic [2:0] Mode;

  int checks = 0;
  int failures = 0;
  bit bank_on = 0;
  int hup_cnt = 0;
  int clrn_lows = 0;

  // Model state.
  int m_mode, m_al, m_rem;
  bit m_blink, p_mb, p_ib, p_sb, p_match;

  clock_mode_ctrl dut (
    .Clk(Clk), .Clr(Clr), .Sec_tick(tick), .Mode_btn(mbtn), .Inc_btn(ibtn),
    .Snooze_btn(sbtn), .Alarm_en(en), .Time_H(th), .Time_M(tm), .Time_S(ts),
    .Alarm_H(ah), .Alarm_M(am), .S_up(S_up), .M_up(M_up), .H_up(H_up),
    .AH_up(AH_up), .AM_up(AM_up), .S_clr_n(S_clr_n), .Mode(Mode), .Blink(Blink),
    .Ring(Ring)
  );

  always #5 Clk = ~Clk;

  function automatic logic [10:0] outs();
    return {S_up, M_up, H_up, AH_up, AM_up, S_clr_n, Mode, Blink, Ring};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_al = 0; m_rem = 0; m_blink = 0;
    p_mb = 0; p_ib = 0; p_sb = 0; p_match = 0;
  endtask

  // One clock: predict from the rules, clock, compare every output.
  task automatic cyc(input string tag);
    bit mr, ir, sr, match, trig;
    bit e_s, e_m, e_h, e_ah, e_am, e_clrn;
    int nmode;
    logic [10:0] exp;
    mr = mbtn && !p_mb;
    ir = ibtn && !p_ib;
    sr = sbtn && !p_sb;
    {e_s, e_m, e_h, e_ah, e_am} = '0;
    e_clrn = 1;
    nmode = m_mode;
    if (mr) begin
      nmode = (m_mode + 1) % 5;
      if (m_mode == 2) e_clrn = 0;
    end else if (ir) begin
      e_h = (m_mode == 1); e_m = (m_mode == 2); e_ah = (m_mode == 3); e_am = (m_mode == 4);
    end
    if (m_mode == 0 && tick) begin
      e_s = 1;
      e_m = (ts == 59);
      e_h = (ts == 59) && (tm == 59);
    end
    m_blink = (nmode == 0) ? 1'b0 : (m_blink ^ tick);
    match = (m_mode == 0) && en && (th == ah) && (tm == am) && (ts == 0);
    trig = match && !p_match;
    if (!en || mr) begin
      m_al = 0; m_rem = 0;
    end else if (m_al == 0) begin
      if (trig) begin m_al = 1; m_rem = RING; end
    end else if (m_al == 1) begin
      if (sr) begin m_al = 2; m_rem = SNOOZE; end
      else if (tick) begin m_rem--; if (m_rem == 0) m_al = 0; end
    end else begin
      if (tick) begin m_rem--; if (m_rem == 0) begin m_al = 1; m_rem = RING; end end
    end
    m_mode = nmode;
    p_mb = mbtn; p_ib = ibtn; p_sb = sbtn; p_match = match;
    exp = {e_s, e_m, e_h, e_ah, e_am, e_clrn, 3'(m_mode), m_blink, (m_al == 1)};
    @(posedge Clk);
    #1;
    chk(tag, 32'(outs()), 32'(exp));
    if (H_up) hup_cnt++;
    if (!S_clr_n) clrn_lows++;
    if (bank_on) begin
      if (S_up) ts = (ts == 59) ? 6'd0 : ts + 6'd1;
      if (M_up) tm = (tm == 59) ? 6'd0 : tm + 6'd1;
      if (H_up) th = (th == 23) ? 5'd0 : th + 5'd1;
    end
    @(negedge Clk);
    tick = 0;
  endtask

  task automatic press_mode();
    mbtn = 1; cyc("mode_press");
    mbtn = 0; cyc("mode_release");
  endtask

  task automatic tick_idle(input string tag);
    tick = 1; cyc(tag);
    cyc(tag);
  endtask

  initial begin
    Clr = 0; tick = 0; mbtn = 0; ibtn = 0; sbtn = 0; en = 0;
    th = 0; tm = 0; ts = 0; ah = 5'd7; am = 6'd30;
    model_reset();
    @(posedge Clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'(RST_VEC));
    @(negedge Clk);
    Clr = 1;
    cyc("post_reset");

    // Midnight rollover through a small counter bank.
    bank_on = 1; th = 5'd23; tm = 6'd59; ts = 6'd58;
    tick = 1; cyc("tick_58");
    tick = 1; cyc("tick_59");
    chk("bank_midnight", 32'({th, tm, ts}), 32'd0);
    bank_on = 0;

    // Alarm ring for its full duration, no retrigger while still at 07:30:00.
    en = 1; th = 5'd7; tm = 6'd29; ts = 6'd59;
    cyc("pre_alarm");
    tm = 6'd30; ts = 6'd0;
    cyc("alarm_hit");
    chk("ring_on", 32'(Ring), 32'd1);
    for (int i = 0; i < RING; i++) tick_idle("ringing");
    chk("ring_timeout", 32'(Ring), 32'd0);
    for (int i = 0; i < 5; i++) tick_idle("no_retrigger");
    chk("no_retrigger", 32'(Ring), 32'd0);

    // Snooze ignored while idle, then snooze and re-ring.
    sbtn = 1; cyc("snz_idle"); sbtn = 0; cyc("snz_idle_rel");
    ts = 6'd1; cyc("leave_match");
    ts = 6'd0; cyc("rematch");
    chk("ring_again", 32'(Ring), 32'd1);
    sbtn = 1; cyc("snooze"); sbtn = 0; cyc("snooze_rel");
    chk("snooze_quiet", 32'(Ring), 32'd0);
    for (int i = 0; i < SNOOZE - 1; i++) begin
      tick = 1; cyc("snoozing");
    end
    chk("snooze_hold", 32'(Ring), 32'd0);
    tick = 1; cyc("snooze_end");
    chk("reringing", 32'(Ring), 32'd1);
    en = 0; cyc("en_drop");
    chk("en_drop", 32'(Ring), 32'd0);

    // Set modes: three Inc edges (one held), S_clr_n only on leaving SET_TM.
    th = 5'd3; tm = 6'd4; ts = 6'd5;
    press_mode();
    chk("mode_th", 32'(Mode), 32'd1);
    hup_cnt = 0;
    ibtn = 1; cyc("inc_held"); cyc("inc_held"); cyc("inc_held"); ibtn = 0; cyc("inc_rel");
    ibtn = 1; cyc("inc2"); ibtn = 0; cyc("inc2_rel");
    ibtn = 1; cyc("inc3"); ibtn = 0; cyc("inc3_rel");
    chk("h_up_count", 32'(hup_cnt), 32'd3);
    tick = 1; cyc("set_tick");
    clrn_lows = 0;
    press_mode();
    chk("mode_tm", 32'(Mode), 32'd2);
    chk("no_clr_entering_tm", 32'(clrn_lows), 32'd0);
    press_mode();
    chk("mode_ah", 32'(Mode), 32'd3);
    chk("clr_leaving_tm", 32'(clrn_lows), 32'd1);
    press_mode();
    chk("blink_in_am", 32'(Blink), 32'd1);

    // Asynchronous clear mid-set.
    #2 Clr = 0;
    #1;
    chk("async_clr", 32'(outs()), 32'(RST_VEC));
    model_reset();
    @(negedge Clk);
    Clr = 1;
    cyc("after_clr");

    // Mode and Inc edges together: mode wins.
    hup_cnt = 0;
    mbtn = 1; ibtn = 1; cyc("mode_and_inc");
    mbtn = 0; ibtn = 0; cyc("mode_and_inc_rel");
    chk("mode_inc_mode", 32'(Mode), 32'd1);
    chk("mode_inc_no_up", 32'(hup_cnt), 32'd0);
    for (int i = 0; i < 4; i++) press_mode();

    // Random traffic around the alarm time.
    ah = 5'($urandom_range(0, 23));
    am = 6'($urandom_range(0, 59));
    for (int i = 0; i < 1500; i++) begin
      tick = ($urandom_range(0, 4) < 2);
      if ($urandom_range(0, 15) == 0) mbtn = ~mbtn;
      if ($urandom_range(0, 3) == 0) ibtn = ~ibtn;
      if ($urandom_range(0, 5) == 0) sbtn = ~sbtn;
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) != 0) begin
        th = ah; tm = am;
        ts = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
      end else begin
        th = 5'($urandom_range(0, 23));
        tm = 6'($urandom_range(0, 59));
        ts = 6'($urandom_range(0, 59));
      end
      cyc("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
